// File: rtl/risc16_mmio_pkg.sv
// Shared definitions for the risc16 memory-mapped peripherals: timer register
// offsets, CTRL/STATUS bit positions and the CTRL register layout.
package risc16_mmio_pkg;

  localparam logic [1:0] TMR_CTRL    = 2'd0;
  localparam logic [1:0] TMR_COUNT   = 2'd1;
  localparam logic [1:0] TMR_COMPARE = 2'd2;
  localparam logic [1:0] TMR_STATUS  = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO_CLR  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  typedef struct packed {
    logic [7:0] presc;
    logic [4:0] rsvd;
    logic       irq_en;
    logic       auto_clr;
    logic       en;
  } tmr_ctrl_t;

endpackage

// File: rtl/mmio_prescaler.sv
// Timer prescaler: counts 0..i_div while enabled and raises o_tick in the
// cycle the count equals i_div. Held at 0 while disabled or cleared.
module mmio_prescaler #(
  parameter int p_PRESC_LEN = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [p_PRESC_LEN-1:0] i_div,
  input  logic                   i_clr,
  output logic                   o_tick
);

  logic [p_PRESC_LEN-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_div);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer on the core data bus: 4-word window with CTRL, COUNT,
// COMPARE and W1C STATUS; combinational read, write on the next rising edge.
module mmio_timer
  import risc16_mmio_pkg::*;
#(
  parameter logic [15:0] p_BASE_ADDR = 16'h0400,
  parameter int          p_PRESC_LEN = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_mem_addr,
  input  logic [15:0] i_mem_wr_data,
  input  logic        i_mem_wr_en,
  output logic [15:0] o_mem_rd_data,
  output logic        o_sel,
  output logic        o_irq
);

  if (p_BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("mmio_timer: p_BASE_ADDR must be 4-word aligned");
  end
  if (p_PRESC_LEN < 1 || p_PRESC_LEN > 8) begin : g_bad_presc
    $error("mmio_timer: p_PRESC_LEN must be 1..8");
  end

  localparam logic [7:0] c_PRESC_MASK = 8'((1 << p_PRESC_LEN) - 1);

  tmr_ctrl_t   r_ctrl;
  logic [15:0] r_count;
  logic [15:0] r_compare;
  logic        r_match;
  logic        r_ovf;

  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic [7:0]  w_new_presc;
  logic        w_en_eff;
  logic        w_presc_clr;
  logic        w_tick;
  logic        w_hit;
  logic        w_set_match;
  logic        w_set_ovf;
  logic [15:0] w_count_inc;

  assign o_sel        = (i_mem_addr[15:2] == p_BASE_ADDR[15:2]);
  assign w_off        = i_mem_addr[1:0];
  assign w_wr         = o_sel & i_mem_wr_en;
  assign w_wr_ctrl    = w_wr && (w_off == TMR_CTRL);
  assign w_wr_count   = w_wr && (w_off == TMR_COUNT);
  assign w_wr_compare = w_wr && (w_off == TMR_COMPARE);
  assign w_wr_status  = w_wr && (w_off == TMR_STATUS);
  assign w_new_presc  = i_mem_wr_data[15:CTRL_PRESC_LSB] & c_PRESC_MASK;

  // An EN 1->0 write suppresses the tick of its own cycle.
  assign w_en_eff    = r_ctrl.en & ~(w_wr_ctrl & ~i_mem_wr_data[CTRL_EN]);
  assign w_presc_clr = w_wr_ctrl && (w_new_presc != r_ctrl.presc);

  mmio_prescaler #(
    .p_PRESC_LEN (p_PRESC_LEN)
  ) u_presc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_en_eff),
    .i_div   (r_ctrl.presc[p_PRESC_LEN-1:0]),
    .i_clr   (w_presc_clr),
    .o_tick  (w_tick)
  );

  // COUNT+1 wraps FFFF->0 naturally, covering both overflow and the
  // COMPARE==COUNT==FFFF case; AUTO_CLR only matters on a match.
  assign w_hit       = (r_count == r_compare);
  assign w_set_match = w_tick & w_hit;
  assign w_set_ovf   = w_tick & (r_count == 16'hFFFF);
  assign w_count_inc = (w_hit && r_ctrl.auto_clr) ? 16'h0000 : r_count + 16'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl    <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_match   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl.presc    <= w_new_presc;
        r_ctrl.rsvd     <= '0;
        r_ctrl.irq_en   <= i_mem_wr_data[CTRL_IRQ_EN];
        r_ctrl.auto_clr <= i_mem_wr_data[CTRL_AUTO_CLR];
        r_ctrl.en       <= i_mem_wr_data[CTRL_EN];
      end
      if (w_wr_count) begin
        r_count <= i_mem_wr_data;
      end else if (w_tick) begin
        r_count <= w_count_inc;
      end
      if (w_wr_compare) begin
        r_compare <= i_mem_wr_data;
      end
      r_match <= w_set_match | (r_match & ~(w_wr_status & i_mem_wr_data[STAT_MATCH]));
      r_ovf   <= w_set_ovf   | (r_ovf   & ~(w_wr_status & i_mem_wr_data[STAT_OVF]));
    end
  end

  always_comb begin
    o_mem_rd_data = 16'h0000;
    if (o_sel) begin
      case (w_off)
        TMR_CTRL:    o_mem_rd_data = r_ctrl;
        TMR_COUNT:   o_mem_rd_data = r_count;
        TMR_COMPARE: o_mem_rd_data = r_compare;
        default:     o_mem_rd_data = {14'b0, r_ovf, r_match};
      endcase
    end
  end

  assign o_irq = r_ctrl.irq_en & (r_match | r_ovf);

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized bus
// traffic compared every cycle against a behavioural model of the timer.
module tb_mmio_timer;

  localparam logic [15:0] BASE = 16'h0400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata;
  logic        sel;
  logic        irq;

  always #10 clk = ~clk;

  mmio_timer #(
    .p_BASE_ADDR (BASE),
    .p_PRESC_LEN (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_mem_addr    (addr),
    .i_mem_wr_data (wdata),
    .i_mem_wr_en   (we),
    .o_mem_rd_data (rdata),
    .o_sel         (sel),
    .o_irq         (irq)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model state
  bit          m_en, m_ac, m_ie, m_match, m_ovf;
  logic [7:0]  m_presc, m_pc;
  logic [15:0] m_count, m_cmp;

  task automatic model_reset();
    m_en = 0; m_ac = 0; m_ie = 0; m_match = 0; m_ovf = 0;
    m_presc = 0; m_pc = 0; m_count = 0; m_cmp = 0;
  endtask

  function automatic bit model_sel(input logic [15:0] a);
    return a[15:2] == BASE[15:2];
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (!model_sel(a)) return 16'h0000;
    case (a[1:0])
      2'd0:    return {m_presc, 5'b0, m_ie, m_ac, m_en};
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {14'b0, m_ovf, m_match};
    endcase
  endfunction

  task automatic model_step(input logic [15:0] a, input logic [15:0] d, input bit w);
    bit wr, run, tick, setm, seto;
    logic [15:0] nc;
    logic [7:0]  npc;
    wr   = w && model_sel(a);
    run  = m_en && !(wr && a[1:0] == 2'd0 && !d[0]);
    tick = run && (m_pc == m_presc);
    setm = 0; seto = 0;
    nc   = m_count;
    if (tick) begin
      if (m_count == m_cmp) begin
        setm = 1;
        if (m_count == 16'hFFFF) seto = 1;
        nc = m_ac ? 16'h0000 : 16'(m_count + 1);
      end else if (m_count == 16'hFFFF) begin
        seto = 1;
        nc = 16'h0000;
      end else begin
        nc = 16'(m_count + 1);
      end
    end
    npc = (!run || tick) ? 8'h00 : 8'(m_pc + 1);
    if (wr && a[1:0] == 2'd0 && d[15:8] != m_presc) npc = 8'h00;
    m_pc = npc;
    if (wr) begin
      case (a[1:0])
        2'd0: begin m_presc = d[15:8]; m_ie = d[2]; m_ac = d[1]; m_en = d[0]; end
        2'd1: nc = d;
        2'd2: m_cmp = d;
        default: begin
          if (d[0]) m_match = 0;
          if (d[1]) m_ovf = 0;
        end
      endcase
    end
    m_count = nc;
    if (setm) m_match = 1;
    if (seto) m_ovf = 1;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, commit at posedge.
  logic [15:0] rd;
  bit          rsel, rirq;

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] d, input bit w);
    @(negedge clk);
    addr = a; wdata = d; we = w;
    #1;
    chk({tag, "_rd"},  rdata, model_read(a));
    chk({tag, "_sel"}, 16'(sel), 16'(model_sel(a)));
    chk({tag, "_irq"}, 16'(irq), 16'(m_ie && (m_match || m_ovf)));
    rd = rdata; rsel = sel; rirq = irq;
    @(posedge clk);
    model_step(a, d, w);
  endtask

  // Asynchronous reset mid-run: everything must read 0 before the next edge.
  task automatic do_reset();
    @(negedge clk);
    we = 0; addr = BASE + 16'd3;
    #1 rst_n = 0;
    model_reset();
    #1 chk("rst_irq", 16'(irq), 16'h0000);
    chk("rst_status", rdata, 16'h0000);
    addr = BASE + 16'd1;
    #1 chk("rst_count", rdata, 16'h0000);
    addr = BASE;
    #1 chk("rst_ctrl", rdata, 16'h0000);
    addr = BASE + 16'd2;
    #1 chk("rst_compare", rdata, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; addr = 0; wdata = 0; we = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) op("init", BASE + 16'(i), 16'h0, 1'b0);

    // Free run, PRESC=0
    op("fr_cmp", BASE + 16'd2, 16'd5, 1'b1);
    op("fr_ctrl", BASE, 16'h0001, 1'b1);
    for (int k = 0; k < 8; k++) begin
      op("fr_cnt", BASE + 16'd1, 16'h0, 1'b0);
      chk("free_cnt", rd, 16'(k));
    end
    op("fr_stat", BASE + 16'd3, 16'h0, 1'b0);
    chk("free_match", rd, 16'h0001);
    op("fr_irqen", BASE, 16'h0005, 1'b1);
    op("fr_irq", BASE + 16'd3, 16'h0, 1'b0);
    chk("free_irq", 16'(rirq), 16'h0001);

    do_reset();

    // Prescale and auto-clear
    op("pa_cmp", BASE + 16'd2, 16'd2, 1'b1);
    op("pa_ctrl", BASE, 16'h0303, 1'b1);
    for (int k = 0; k < 24; k++) begin
      op("pa_cnt", BASE + 16'd1, 16'h0, 1'b0);
      chk("presc_cnt", rd, 16'((k / 4) % 3));
    end
    op("pa_stat", BASE + 16'd3, 16'h0, 1'b0);
    chk("presc_match", rd, 16'h0001);

    do_reset();

    // Overflow and IRQ
    op("ov_cnt", BASE + 16'd1, 16'hFFFE, 1'b1);
    op("ov_cmp", BASE + 16'd2, 16'h1000, 1'b1);
    op("ov_ctrl", BASE, 16'h0005, 1'b1);
    op("ov_s0", BASE + 16'd3, 16'h0, 1'b0);
    op("ov_s1", BASE + 16'd3, 16'h0, 1'b0);
    op("ov_s2", BASE + 16'd3, 16'h0, 1'b0);
    chk("ovf_flag", rd, 16'h0002);
    chk("ovf_irq", 16'(rirq), 16'h0001);
    op("ov_w1c", BASE + 16'd3, 16'h0002, 1'b1);
    op("ov_s3", BASE + 16'd3, 16'h0, 1'b0);
    chk("ovf_clr", rd, 16'h0000);
    chk("ovf_irq_clr", 16'(rirq), 16'h0000);

    do_reset();

    // Collisions
    op("co_ctrl", BASE, 16'h0001, 1'b1);
    op("co_wcnt", BASE + 16'd1, 16'h0100, 1'b1);
    op("co_rcnt", BASE + 16'd1, 16'h0, 1'b0);
    chk("coll_cnt", rd, 16'h0100);
    op("co_cmp", BASE + 16'd2, 16'h0104, 1'b1);
    op("co_r1", BASE + 16'd1, 16'h0, 1'b0);
    op("co_r2", BASE + 16'd1, 16'h0, 1'b0);
    chk("coll_pre", rd, 16'h0103);
    op("co_w1c", BASE + 16'd3, 16'h0001, 1'b1);
    op("co_stat", BASE + 16'd3, 16'h0, 1'b0);
    chk("coll_w1c", rd, 16'h0001);

    do_reset();

    // Decode
    op("dc_lo", 16'h03FF, 16'hFFFF, 1'b1);
    chk("dec_lo_sel", 16'(rsel), 16'h0000);
    chk("dec_lo_rd", rd, 16'h0000);
    op("dc_hi", 16'h0404, 16'hFFFF, 1'b1);
    chk("dec_hi_sel", 16'(rsel), 16'h0000);
    chk("dec_hi_rd", rd, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      op("dc_in", BASE + 16'(i), 16'h0, 1'b0);
      chk("dec_in_sel", 16'(rsel), 16'h0001);
      chk("dec_in_rd", rd, 16'h0000);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a, d;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = BASE + 16'($urandom_range(0, 3));
      else if (r == 8) a = 16'h03FC + 16'($urandom_range(0, 3));
      else             a = 16'($urandom);
      d = 16'($urandom);
      case (a[1:0])
        2'd0: begin
          d[15:8] = 8'($urandom_range(0, 3));
          d[0]    = ($urandom_range(0, 5) != 0);
        end
        2'd1, 2'd2: d = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 7))
                                                    : 16'hFFF8 + 16'($urandom_range(0, 7));
        default: d = 16'($urandom_range(0, 3));
      endcase
      op("rnd", a, d, ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
